// File: rtl/chroni_pkg.sv
// Definitions shared by the chroni fetch engines: controller state codes,
// pixel width, default palette indices and the memory-fetch kind.
package chroni_pkg;

    localparam int PIX_W = 4;

    localparam logic [PIX_W-1:0] CHRONI_DEF_FG = 4'hF;
    localparam logic [PIX_W-1:0] CHRONI_DEF_BG = 4'h1;

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_TXT_REQ  = 4'd1;
    localparam logic [3:0] ST_TXT_WAIT = 4'd2;
    localparam logic [3:0] ST_ATR_REQ  = 4'd3;
    localparam logic [3:0] ST_ATR_WAIT = 4'd4;
    localparam logic [3:0] ST_FNT_REQ  = 4'd5;
    localparam logic [3:0] ST_FNT_WAIT = 4'd6;
    localparam logic [3:0] ST_EMIT     = 4'd7;
    localparam logic [3:0] ST_DONE     = 4'd8;

    typedef enum logic [1:0] {
        FETCH_NONE,
        FETCH_TEXT,
        FETCH_ATTR,
        FETCH_FONT
    } fetch_kind_t;

    // Which memory stream a request state addresses; the bitmap fetcher reuses this.
    function automatic fetch_kind_t req_kind(input logic [3:0] st);
        case (st)
            ST_TXT_REQ: return FETCH_TEXT;
            ST_ATR_REQ: return FETCH_ATTR;
            ST_FNT_REQ: return FETCH_FONT;
            default:    return FETCH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/chroni_pix_shifter.sv
// Serialises one glyph row into 8 palette-index pixel writes, MSB first,
// at consecutive line-buffer addresses; done marks the eighth write.
module chroni_pix_shifter
    import chroni_pkg::*;
#(
    parameter int PIX_AW = 11
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        glyph,
    input  logic [PIX_W-1:0]  fg,
    input  logic [PIX_W-1:0]  bg,
    input  logic [PIX_AW-1:0] base,
    output logic              wr_en,
    output logic [PIX_AW-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              done
);

    logic [7:0]        shift_q;
    logic [PIX_W-1:0]  fg_q;
    logic [PIX_W-1:0]  bg_q;
    logic [PIX_AW-1:0] base_q;
    logic [2:0]        k;
    logic              active;

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            shift_q <= '0;
            fg_q    <= '0;
            bg_q    <= '0;
            base_q  <= '0;
            k       <= '0;
            active  <= 1'b0;
        end else if (start) begin
            shift_q <= glyph;
            fg_q    <= fg;
            bg_q    <= bg;
            base_q  <= base;
            k       <= '0;
            active  <= 1'b1;
        end else if (active) begin
            shift_q <= {shift_q[6:0], 1'b0};
            k       <= k + 3'd1;
            if (k == 3'd7) begin
                active <= 1'b0;
            end
        end
    end

    assign wr_en   = active;
    assign wr_addr = base_q + PIX_AW'(k);
    assign wr_data = shift_q[7] ? fg_q : bg_q;
    assign done    = active && (k == 3'd7);

endmodule

// File: rtl/chroni_text_fetch.sv
// Scanline text renderer: fetches (or reuses cached) char codes and attributes,
// then one font row per column, and writes COLS*8 pixels into a line-buffer half.
module chroni_text_fetch
    import chroni_pkg::*;
#(
    parameter int               COLS      = 80,
    parameter int               FONT_ROWS = 8,
    parameter int               ADDR_W    = 16,
    parameter logic [PIX_W-1:0] DEF_FG    = CHRONI_DEF_FG,
    parameter logic [PIX_W-1:0] DEF_BG    = CHRONI_DEF_BG,
    localparam int              SCAN_W    = $clog2(FONT_ROWS),
    localparam int              PIX_AW    = $clog2(2 * COLS * 8),
    localparam int              COL_W     = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic              sys_clk,
    input  logic              reset_n,
    input  logic              line_start,
    input  logic [ADDR_W-1:0] text_base,
    input  logic [ADDR_W-1:0] attr_base,
    input  logic [ADDR_W-1:0] font_base,
    input  logic [SCAN_W-1:0] scan,
    input  logic              fetch_text,
    input  logic              attr_en,
    input  logic              buf_sel,
    output logic [ADDR_W-1:0] addr_out,
    output logic              rd_req,
    input  logic              rd_ack,
    input  logic [7:0]        data_in,
    output logic              pix_wr_en,
    output logic [PIX_AW-1:0] pix_wr_addr,
    output logic [PIX_W-1:0]  pix_wr_data,
    output logic              busy,
    output logic              line_done,
    output logic              overrun
);

    logic [3:0]        state;
    logic [COL_W-1:0]  col;
    logic [ADDR_W-1:0] text_q;
    logic [ADDR_W-1:0] attr_q;
    logic [ADDR_W-1:0] font_q;
    logic [SCAN_W-1:0] scan_q;
    logic              attr_en_q;
    logic              buf_q;

    logic [7:0] code_cache [COLS];
    logic [7:0] attr_cache [COLS];

    logic              last_col;
    logic [ADDR_W-1:0] req_addr;
    logic [PIX_W-1:0]  cur_fg;
    logic [PIX_W-1:0]  cur_bg;
    logic [PIX_AW-1:0] pix_base;
    logic              shift_start;
    logic              shift_done;

    assign last_col    = (col == COL_W'(COLS - 1));
    assign cur_fg      = attr_en_q ? attr_cache[col][3:0] : DEF_FG;
    assign cur_bg      = attr_en_q ? attr_cache[col][7:4] : DEF_BG;
    assign pix_base    = (buf_q ? PIX_AW'(COLS * 8) : '0) + PIX_AW'({col, 3'b000});
    assign shift_start = (state == ST_FNT_WAIT) && rd_ack;

    always_comb begin
        req_addr = '0;
        case (req_kind(state))
            FETCH_TEXT: req_addr = text_q + ADDR_W'(col);
            FETCH_ATTR: req_addr = attr_q + ADDR_W'(col);
            FETCH_FONT: req_addr = font_q + (ADDR_W'(code_cache[col]) << SCAN_W) + ADDR_W'(scan_q);
            default:    req_addr = '0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            col       <= '0;
            rd_req    <= 1'b0;
            addr_out  <= '0;
            overrun   <= 1'b0;
            text_q    <= '0;
            attr_q    <= '0;
            font_q    <= '0;
            scan_q    <= '0;
            attr_en_q <= 1'b0;
            buf_q     <= 1'b0;
        end else begin
            overrun <= line_start && (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (line_start) begin
                        text_q    <= text_base;
                        attr_q    <= attr_base;
                        font_q    <= font_base;
                        scan_q    <= scan;
                        attr_en_q <= attr_en;
                        buf_q     <= buf_sel;
                        col       <= '0;
                        state     <= fetch_text ? ST_TXT_REQ : ST_FNT_REQ;
                    end
                end
                ST_TXT_REQ: begin
                    addr_out <= req_addr;
                    rd_req   <= 1'b1;
                    state    <= ST_TXT_WAIT;
                end
                ST_ATR_REQ: begin
                    addr_out <= req_addr;
                    rd_req   <= 1'b1;
                    state    <= ST_ATR_WAIT;
                end
                ST_FNT_REQ: begin
                    addr_out <= req_addr;
                    rd_req   <= 1'b1;
                    state    <= ST_FNT_WAIT;
                end
                // The text pass walks every column once; the font pass restarts at column 0.
                ST_TXT_WAIT, ST_ATR_WAIT: begin
                    if (rd_ack) begin
                        rd_req <= 1'b0;
                        if (state == ST_TXT_WAIT && attr_en_q) begin
                            state <= ST_ATR_REQ;
                        end else if (last_col) begin
                            col   <= '0;
                            state <= ST_FNT_REQ;
                        end else begin
                            col   <= col + COL_W'(1);
                            state <= ST_TXT_REQ;
                        end
                    end
                end
                ST_FNT_WAIT: begin
                    if (rd_ack) begin
                        rd_req <= 1'b0;
                        state  <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (shift_done) begin
                        if (last_col) begin
                            state <= ST_DONE;
                        end else begin
                            col   <= col + COL_W'(1);
                            state <= ST_FNT_REQ;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Cache is deliberately not cleared by reset; a line after reset must refetch.
    always_ff @(posedge sys_clk) begin
        if (reset_n && rd_ack) begin
            if (state == ST_TXT_WAIT) begin
                code_cache[col] <= data_in;
            end
            if (state == ST_ATR_WAIT) begin
                attr_cache[col] <= data_in;
            end
        end
    end

    chroni_pix_shifter #(
        .PIX_AW (PIX_AW)
    ) u_shifter (
        .sys_clk (sys_clk),
        .reset_n (reset_n),
        .start   (shift_start),
        .glyph   (data_in),
        .fg      (cur_fg),
        .bg      (cur_bg),
        .base    (pix_base),
        .wr_en   (pix_wr_en),
        .wr_addr (pix_wr_addr),
        .wr_data (pix_wr_data),
        .done    (shift_done)
    );

    assign busy      = (state != ST_IDLE) && (state != ST_DONE);
    assign line_done = (state == ST_DONE);

endmodule

// File: tb/tb_chroni_text_fetch.sv
// Self-checking bench for chroni_text_fetch (COLS=4): random-latency memory
// responder plus a scanline-level reference model of reads and pixel writes.
module tb_chroni_text_fetch;

    localparam int COLS      = 4;
    localparam int FONT_ROWS = 8;
    localparam int LIMIT     = 4000;

    logic        sys_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        line_start = 1'b0;
    logic [15:0] text_base = '0;
    logic [15:0] attr_base = '0;
    logic [15:0] font_base = '0;
    logic [2:0]  scan = '0;
    logic        fetch_text = 1'b0;
    logic        attr_en = 1'b0;
    logic        buf_sel = 1'b0;
    logic [15:0] addr_out;
    logic        rd_req;
    logic        rd_ack = 1'b0;
    logic [7:0]  data_in = '0;
    logic        pix_wr_en;
    logic [5:0]  pix_wr_addr;
    logic [3:0]  pix_wr_data;
    logic        busy;
    logic        line_done;
    logic        overrun;

    chroni_text_fetch #(
        .COLS      (COLS),
        .FONT_ROWS (FONT_ROWS),
        .ADDR_W    (16)
    ) dut (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .line_start  (line_start),
        .text_base   (text_base),
        .attr_base   (attr_base),
        .font_base   (font_base),
        .scan        (scan),
        .fetch_text  (fetch_text),
        .attr_en     (attr_en),
        .buf_sel     (buf_sel),
        .addr_out    (addr_out),
        .rd_req      (rd_req),
        .rd_ack      (rd_ack),
        .data_in     (data_in),
        .pix_wr_en   (pix_wr_en),
        .pix_wr_addr (pix_wr_addr),
        .pix_wr_data (pix_wr_data),
        .busy        (busy),
        .line_done   (line_done),
        .overrun     (overrun)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad = 0;

    logic [7:0]  mem [65536];
    logic [7:0]  m_code [COLS];
    logic [7:0]  m_attr [COLS];
    logic [15:0] req_log [$];
    logic [15:0] exp_req [$];
    logic [9:0]  pix_log [$];
    logic [9:0]  exp_pix [$];

    int          max_lat = 0;
    bit          hold_ack = 0;
    bit          inject_ack = 0;
    bit          waiting = 0;
    int          wait_cnt = 0;
    logic [15:0] held_addr = '0;

    // Memory responder: random ack latency, checks request stability and no re-request after ack.
    initial begin
        forever begin
            @(negedge sys_clk);
            if (rd_ack) begin
                rd_ack = 1'b0;
                total++;
                if (rd_req !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL req_after_ack: rd_req=%b want 0", rd_req);
                end
            end else if (!reset_n) begin
                waiting = 0;
            end else if (inject_ack) begin
                inject_ack = 0;
                waiting = 0;
                rd_ack = 1'b1;
                data_in = 8'hFF;
            end else if (rd_req === 1'b1) begin
                if (!waiting) begin
                    waiting = 1;
                    wait_cnt = $urandom_range(max_lat);
                    held_addr = addr_out;
                    req_log.push_back(addr_out);
                end else begin
                    total++;
                    if (addr_out !== held_addr) begin
                        bad++;
                        $display("[TB] FAIL addr_stable: addr_out=%h want %h", addr_out, held_addr);
                    end
                end
                if (wait_cnt == 0) begin
                    if (!hold_ack) begin
                        rd_ack = 1'b1;
                        data_in = mem[addr_out];
                        waiting = 0;
                    end
                end else begin
                    wait_cnt--;
                end
            end else if (waiting) begin
                total++;
                bad++;
                $display("[TB] FAIL req_dropped: rd_req=%b before ack, want 1", rd_req);
                waiting = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge sys_clk);
            if (pix_wr_en === 1'b1) pix_log.push_back({pix_wr_addr, pix_wr_data});
        end
    end

    // Reference model: the reads and pixel writes one scanline must produce.
    task automatic build_expect(input logic [15:0] tb, input logic [15:0] ab, input logic [15:0] fb,
                                input logic [2:0] sc, input logic ft, input logic ae, input logic bs);
        logic [15:0] fa;
        logic [7:0]  g;
        logic [3:0]  fg;
        logic [3:0]  bg;
        int          a;
        exp_req.delete();
        exp_pix.delete();
        if (ft) begin
            for (int c = 0; c < COLS; c++) begin
                exp_req.push_back(tb + 16'(c));
                m_code[c] = mem[tb + 16'(c)];
                if (ae) begin
                    exp_req.push_back(ab + 16'(c));
                    m_attr[c] = mem[ab + 16'(c)];
                end
            end
        end
        for (int c = 0; c < COLS; c++) begin
            fa = 16'((int'(fb) + int'(m_code[c]) * FONT_ROWS + int'(sc)) % 65536);
            exp_req.push_back(fa);
            g  = mem[fa];
            fg = ae ? m_attr[c][3:0] : 4'hF;
            bg = ae ? m_attr[c][7:4] : 4'h1;
            for (int k = 0; k < 8; k++) begin
                a = (bs ? COLS * 8 : 0) + c * 8 + k;
                exp_pix.push_back({6'(a), g[7-k] ? fg : bg});
            end
        end
    endtask

    task automatic do_line(input logic [15:0] tb, input logic [15:0] ab, input logic [15:0] fb,
                           input logic [2:0] sc, input logic ft, input logic ae, input logic bs,
                           input int lat, input int ovr_at,
                           output int cyc, output logic to, output logic o1, output logic o2);
        o1 = 1'b0;
        o2 = 1'b0;
        req_log.delete();
        pix_log.delete();
        max_lat = lat;
        build_expect(tb, ab, fb, sc, ft, ae, bs);
        @(negedge sys_clk);
        text_base = tb; attr_base = ab; font_base = fb; scan = sc;
        fetch_text = ft; attr_en = ae; buf_sel = bs;
        line_start = 1'b1;
        cyc = 0;
        to = 1'b1;
        for (int i = 0; i < LIMIT; i++) begin
            @(negedge sys_clk);
            line_start = 1'b0;
            cyc++;
            if (ovr_at != 0 && cyc == ovr_at) begin
                line_start = 1'b1;
                buf_sel = ~bs;
                text_base = text_base + 16'h0100;
            end
            if (cyc == ovr_at + 1) o1 = overrun;
            if (cyc == ovr_at + 2) o2 = overrun;
            if (line_done === 1'b1) begin
                to = 1'b0;
                break;
            end
        end
        line_start = 1'b0;
        @(negedge sys_clk);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        total++;
        if ({rd_req, pix_wr_en, busy, line_done, overrun} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL reset_ctl: req/wr/busy/done/ovr=%b want 00000",
                     {rd_req, pix_wr_en, busy, line_done, overrun});
        end
        total++;
        if (addr_out !== 16'h0) begin
            bad++;
            $display("[TB] FAIL reset_addr: got %h want 0000", addr_out);
        end
        total++;
        if ({pix_wr_addr, pix_wr_data} !== 10'h0) begin
            bad++;
            $display("[TB] FAIL reset_pix: addr=%h data=%h want 0/0", pix_wr_addr, pix_wr_data);
        end
        reset_n = 1'b1;
        @(negedge sys_clk);
    endtask

    task automatic test_mono;
        int cyc; logic to, o1, o2;
        logic [3:0] pat [8];
        pat = '{4'hF, 4'h1, 4'hF, 4'h1, 4'h1, 4'hF, 4'h1, 4'hF};
        for (int c = 0; c < COLS; c++) begin
            mem[16'h0400 + c] = 8'(8'h41 + c);
            mem[16'h1000 + (8'h41 + c) * 8 + 3] = 8'hA5;
        end
        do_line(16'h0400, 16'h0000, 16'h1000, 3'd3, 1'b1, 1'b0, 1'b0, 0, 0, cyc, to, o1, o2);
        total++;
        if (to) begin bad++; $display("[TB] FAIL mono_done: line_done missing after %0d cycles", cyc); end
        total++;
        if (cyc != COLS * 12 + 1) begin bad++; $display("[TB] FAIL mono_time: got %0d cycles want %0d", cyc, COLS * 12 + 1); end
        total++;
        if (req_log.size() != exp_req.size()) begin bad++; $display("[TB] FAIL mono_nreq: got %0d want %0d", req_log.size(), exp_req.size()); end
        foreach (exp_req[i]) begin
            total++;
            if (req_log[i] !== exp_req[i]) begin bad++; $display("[TB] FAIL mono_req%0d: got %h want %h", i, req_log[i], exp_req[i]); end
        end
        total++;
        if (req_log[4] !== 16'h120B) begin bad++; $display("[TB] FAIL mono_font0: got %h want 120b", req_log[4]); end
        total++;
        if (pix_log.size() != exp_pix.size()) begin bad++; $display("[TB] FAIL mono_npix: got %0d want %0d", pix_log.size(), exp_pix.size()); end
        foreach (exp_pix[i]) begin
            total++;
            if (pix_log[i] !== exp_pix[i]) begin bad++; $display("[TB] FAIL mono_pix%0d: got %h want %h", i, pix_log[i], exp_pix[i]); end
        end
        for (int k = 0; k < 8; k++) begin
            total++;
            if (pix_log[k] !== {6'(k), pat[k]}) begin bad++; $display("[TB] FAIL mono_pat%0d: got %h want %h", k, pix_log[k], {6'(k), pat[k]}); end
        end
        total++;
        if ({line_done, busy} !== 2'b00) begin bad++; $display("[TB] FAIL mono_after: done/busy=%b want 00", {line_done, busy}); end
    endtask

    task automatic test_attr;
        int cyc; logic to, o1, o2;
        for (int c = 0; c < COLS; c++) begin
            mem[16'h0500 + c] = 8'(8'h50 + c);
            mem[16'h0800 + c] = 8'h2C;
            mem[16'h2000 + (8'h50 + c) * 8 + 5] = 8'hF0;
        end
        do_line(16'h0500, 16'h0800, 16'h2000, 3'd5, 1'b1, 1'b1, 1'b1, 0, 0, cyc, to, o1, o2);
        total++;
        if (to) begin bad++; $display("[TB] FAIL attr_done: line_done missing after %0d cycles", cyc); end
        total++;
        if (cyc != COLS * 14 + 1) begin bad++; $display("[TB] FAIL attr_time: got %0d cycles want %0d", cyc, COLS * 14 + 1); end
        total++;
        if (req_log[1] !== 16'h0800) begin bad++; $display("[TB] FAIL attr_order: second read %h want 0800", req_log[1]); end
        total++;
        if (req_log.size() != exp_req.size()) begin bad++; $display("[TB] FAIL attr_nreq: got %0d want %0d", req_log.size(), exp_req.size()); end
        foreach (exp_req[i]) begin
            total++;
            if (req_log[i] !== exp_req[i]) begin bad++; $display("[TB] FAIL attr_req%0d: got %h want %h", i, req_log[i], exp_req[i]); end
        end
        for (int k = 0; k < 8; k++) begin
            total++;
            if (pix_log[k] !== {6'(32 + k), (k < 4) ? 4'hC : 4'h2}) begin
                bad++; $display("[TB] FAIL attr_pix%0d: got %h want %h", k, pix_log[k], {6'(32 + k), (k < 4) ? 4'hC : 4'h2});
            end
        end
        total++;
        if (pix_log.size() != exp_pix.size()) begin bad++; $display("[TB] FAIL attr_npix: got %0d want %0d", pix_log.size(), exp_pix.size()); end
        foreach (exp_pix[i]) begin
            total++;
            if (pix_log[i] !== exp_pix[i]) begin bad++; $display("[TB] FAIL attr_pixm%0d: got %h want %h", i, pix_log[i], exp_pix[i]); end
        end
    endtask

    task automatic test_cached;
        int cyc; logic to, o1, o2;
        for (int c = 0; c < COLS; c++) begin
            mem[16'h0500 + c] = 8'($urandom);
            mem[16'h0800 + c] = 8'($urandom);
        end
        do_line(16'h0500, 16'h0800, 16'h2000, 3'd2, 1'b0, 1'b1, 1'b0, 0, 0, cyc, to, o1, o2);
        total++;
        if (to) begin bad++; $display("[TB] FAIL cache_done: line_done missing after %0d cycles", cyc); end
        total++;
        if (cyc != COLS * 10 + 1) begin bad++; $display("[TB] FAIL cache_time: got %0d cycles want %0d", cyc, COLS * 10 + 1); end
        total++;
        if (req_log.size() != COLS) begin bad++; $display("[TB] FAIL cache_nreq: got %0d want %0d", req_log.size(), COLS); end
        foreach (exp_req[i]) begin
            total++;
            if (req_log[i] !== exp_req[i]) begin bad++; $display("[TB] FAIL cache_req%0d: got %h want %h", i, req_log[i], exp_req[i]); end
        end
        foreach (exp_pix[i]) begin
            total++;
            if (pix_log[i] !== exp_pix[i]) begin bad++; $display("[TB] FAIL cache_pix%0d: got %h want %h", i, pix_log[i], exp_pix[i]); end
        end
    endtask

    task automatic test_latency;
        int cyc; logic to, o1, o2;
        logic ft;
        for (int n = 0; n < 4; n++) begin
            ft = (n == 0) ? 1'b1 : 1'($urandom_range(1));
            do_line(16'($urandom), 16'($urandom), 16'($urandom), 3'($urandom), ft,
                    1'($urandom_range(1)), 1'($urandom_range(1)), 5, 0, cyc, to, o1, o2);
            total++;
            if (to) begin bad++; $display("[TB] FAIL lat_done%0d: line_done missing after %0d cycles", n, cyc); end
            total++;
            if (req_log.size() != exp_req.size()) begin bad++; $display("[TB] FAIL lat_nreq%0d: got %0d want %0d", n, req_log.size(), exp_req.size()); end
            foreach (exp_req[i]) begin
                total++;
                if (req_log[i] !== exp_req[i]) begin bad++; $display("[TB] FAIL lat_req%0d_%0d: got %h want %h", n, i, req_log[i], exp_req[i]); end
            end
            total++;
            if (pix_log.size() != exp_pix.size()) begin bad++; $display("[TB] FAIL lat_npix%0d: got %0d want %0d", n, pix_log.size(), exp_pix.size()); end
            foreach (exp_pix[i]) begin
                total++;
                if (pix_log[i] !== exp_pix[i]) begin bad++; $display("[TB] FAIL lat_pix%0d_%0d: got %h want %h", n, i, pix_log[i], exp_pix[i]); end
            end
        end
    endtask

    task automatic test_overrun;
        int cyc; logic to, o1, o2;
        do_line(16'h3000, 16'h3100, 16'h4000, 3'd6, 1'b1, 1'b1, 1'b0, 2, 15, cyc, to, o1, o2);
        total++;
        if (to) begin bad++; $display("[TB] FAIL ovr_done: line_done missing after %0d cycles", cyc); end
        total++;
        if (o1 !== 1'b1) begin bad++; $display("[TB] FAIL ovr_pulse: overrun=%b want 1", o1); end
        total++;
        if (o2 !== 1'b0) begin bad++; $display("[TB] FAIL ovr_width: overrun=%b a cycle later, want 0", o2); end
        total++;
        if (pix_log.size() != exp_pix.size()) begin bad++; $display("[TB] FAIL ovr_npix: got %0d want %0d", pix_log.size(), exp_pix.size()); end
        foreach (exp_pix[i]) begin
            total++;
            if (pix_log[i] !== exp_pix[i]) begin bad++; $display("[TB] FAIL ovr_pix%0d: got %h want %h", i, pix_log[i], exp_pix[i]); end
        end
    endtask

    task automatic test_reset_mid;
        int cyc; logic to, o1, o2;
        logic seen;
        int n;
        hold_ack = 1;
        @(negedge sys_clk);
        fetch_text = 1'b0; attr_en = 1'b0; buf_sel = 1'b0; font_base = 16'h5000; scan = 3'd1;
        line_start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge sys_clk);
            line_start = 1'b0;
            if (rd_req === 1'b1) begin seen = 1'b1; break; end
        end
        total++;
        if (!seen) begin bad++; $display("[TB] FAIL rst_req: rd_req=%b want 1 before reset", rd_req); end
        reset_n = 1'b0;
        @(negedge sys_clk);
        total++;
        if ({rd_req, busy, pix_wr_en} !== 3'b000) begin
            bad++; $display("[TB] FAIL rst_mid: req/busy/wr=%b want 000", {rd_req, busy, pix_wr_en});
        end
        @(negedge sys_clk);
        reset_n = 1'b1;
        hold_ack = 0;
        inject_ack = 1;
        n = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge sys_clk);
            if (pix_wr_en === 1'b1 || busy === 1'b1) n++;
        end
        total++;
        if (n != 0) begin bad++; $display("[TB] FAIL rst_late_ack: %0d active cycles after late ack, want 0", n); end
        do_line(16'h6000, 16'h6100, 16'h7000, 3'd7, 1'b1, 1'b1, 1'b1, 3, 0, cyc, to, o1, o2);
        total++;
        if (to) begin bad++; $display("[TB] FAIL rst_line_done: line_done missing after %0d cycles", cyc); end
        total++;
        if (req_log.size() != exp_req.size()) begin bad++; $display("[TB] FAIL rst_nreq: got %0d want %0d", req_log.size(), exp_req.size()); end
        foreach (exp_req[i]) begin
            total++;
            if (req_log[i] !== exp_req[i]) begin bad++; $display("[TB] FAIL rst_req%0d: got %h want %h", i, req_log[i], exp_req[i]); end
        end
        foreach (exp_pix[i]) begin
            total++;
            if (pix_log[i] !== exp_pix[i]) begin bad++; $display("[TB] FAIL rst_pix%0d: got %h want %h", i, pix_log[i], exp_pix[i]); end
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        $display("[TB] starting chroni_text_fetch bench");
        test_reset();
        test_mono();
        test_attr();
        test_cached();
        test_latency();
        test_overrun();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/chroni_text_fetch.md
Name: chroni_text_fetch

Overview:
- Parametrised scanline text renderer for chroni.
- Per scanline it fetches COLS character codes and, optionally, COLS attribute bytes over the shared byte-wide memory read handshake, then the matching font rows.
- Writes COLS*8 palette-index pixels into one half of a double-buffered line buffer.
- Generalises the fixed 80-column mono fetcher: column count, font height and address widths are parameters; adds per-character fg/bg attributes, text-row caching and overrun reporting.

Parameters:
COLS, 80, characters per line (1..255)
FONT_ROWS, 8, scanlines per glyph; power of 2, 8 or 16
ADDR_W, 16, memory address width
DEF_FG, 4'hF, palette index for set pixels when attr_en=0
DEF_BG, 4'h1, palette index for clear pixels when attr_en=0
(local) SCAN_W = clog2(FONT_ROWS); PIX_AW = clog2(2*COLS*8); COL_W = clog2(COLS)

Ports:
sys_clk  in  1  clock
reset_n  in  1  synchronous active-low reset
line_start  in  1  one-cycle pulse: render one scanline
text_base  in  ADDR_W  address of first char code of the text row
attr_base  in  ADDR_W  address of first attribute byte of the text row
font_base  in  ADDR_W  font start; glyph row = font_base + code*FONT_ROWS + scan
scan  in  SCAN_W  glyph row to render
fetch_text  in  1  1 = refetch codes/attrs into cache; 0 = reuse cache
attr_en  in  1  1 = use attribute bytes, hi nibble bg, lo nibble fg
buf_sel  in  1  line buffer half: 0 -> base 0, 1 -> base COLS*8
addr_out  out  ADDR_W  memory read address
rd_req  out  1  read request
rd_ack  in  1  read acknowledge; data_in valid in the ack cycle
data_in  in  8  read data
pix_wr_en  out  1  pixel write strobe
pix_wr_addr  out  PIX_AW  pixel address
pix_wr_data  out  4  palette index
busy  out  1  high from the cycle after an accepted line_start until done
line_done  out  1  one-cycle pulse when the last pixel has been written
overrun  out  1  one-cycle pulse when line_start arrives while busy

Behaviour:
- Reset (sys_clk edge with reset_n=0): state IDLE; rd_req, pix_wr_en, busy, line_done, overrun = 0; addr_out, pix_wr_addr, pix_wr_data = 0; column counter = 0. Cache contents are undefined. Reset mid-handshake drops rd_req immediately; a pending ack is ignored.
- line_start and all inputs are sampled in IDLE only. Inputs are latched at acceptance; later input changes are ignored until the next line.
- line_start while busy: ignored and overrun pulses. The current line completes unaffected.
- States: IDLE, TXT_REQ, TXT_WAIT, ATR_REQ, ATR_WAIT, FNT_REQ, FNT_WAIT, EMIT, DONE.
- Transitions:
  - IDLE -> TXT_REQ if fetch_text; IDLE -> FNT_REQ otherwise.
  - TXT_WAIT on ack -> ATR_REQ if attr_en, else next column TXT_REQ, or FNT_REQ after the last column.
  - ATR_WAIT on ack -> TXT_REQ for the next column, or FNT_REQ after the last column.
  - FNT_WAIT on ack -> EMIT.
  - EMIT after 8 pixels -> FNT_REQ for the next column, or DONE after the last column.
  - DONE -> IDLE.
- Handshake:
  - In a *_REQ state, addr_out is registered and rd_req is set to 1; the state moves to *_WAIT.
  - rd_req holds high and addr_out holds stable until rd_ack=1 is sampled.
  - data_in is captured in that cycle and rd_req is 0 from the next cycle.
  - rd_req never reasserts in the same cycle an ack is seen.
  - Ack with no request outstanding is ignored.
- Addresses:
  - Text: text_base + col.
  - Attribute: attr_base + col.
  - Font: font_base + (code << SCAN_W) + scan.
  - All arithmetic is modulo 2^ADDR_W (wraps silently).
- EMIT writes 8 consecutive cycles, bit 7 first, with pix_wr_en=1.
  - pix_wr_addr = buf_sel*COLS*8 + col*8 + k, for k = 0..7.
  - pix_wr_data = bit ? fg : bg, where fg/bg come from attr[3:0]/attr[7:4] if attr_en, else DEF_FG/DEF_BG.
- line_done pulses in DONE; busy falls in the same cycle.
- Cache: code and attr arrays of COLS bytes. fetch_text=0 with attr_en=1 uses the cached attrs.
- Minimum line time with zero-wait memory is COLS*(2 + 2*attr_en)*fetch_text + COLS*10 + 2 cycles.

Decomposition:
- Shared package chroni_pkg: state encoding, PIX_W=4, DEF_FG/DEF_BG defaults, and the fetch-state enum shared with the future bitmap fetcher.
- One natural sub-module: chroni_pix_shifter. It takes an 8-bit glyph row, fg, bg and base address, and emits 8 pixel writes, raising done on the last one.

Test Plan:
- COLS=4, attr_en=0, fetch_text=1, codes 41,42,43,44, font row 0xA5, text_base 0x0400, scan 3 -> 4 text reads at 0x0400..0x0403. Font reads at font_base+0x20B and following. Pixels F,1,F,1,1,F,1,F at addresses 0..7. line_done after the 32nd write.
- attr_en=1, attr 0x2C, glyph 0xF0, buf_sel=1 -> writes at 32..39 with data C,C,C,C,2,2,2,2. Attribute read follows each text read.
- fetch_text=0 after a cached line -> no TXT/ATR reads issued; only 4 font reads; pixels use cached codes.
- Variable ack latency 0..5 cycles, random -> rd_req stays high and addr_out stays stable until ack. No duplicate request. Results match the zero-wait run.
- line_start pulsed mid-line -> overrun=1 for one cycle; the line completes with the original buf_sel.
- reset_n=0 while FNT_WAIT -> next cycle rd_req=0, busy=0, pix_wr_en=0. A late ack causes no write. A new line after reset renders correctly.
